// File: rtl/policy_deck.sv
`default_nettype none
// ---------------------------------------------------------------------------
// policy_deck : policy-card draw stack, discard pile, hand and enact counters
//               with an LFSR-driven in-place shuffle. Optional POLICY_DECK_PEEK_EN.
// Revision    : 1.0
// ---------------------------------------------------------------------------
module policy_deck #(
  parameter int         N_CARDS   = 17,
  parameter int         N_LIB     = 6,
  parameter logic [7:0] LFSR_SEED = 8'h01
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               op_valid,
  input  logic [2:0]                         op_code,
  input  logic [1:0]                         op_arg,
  output logic                               op_ready,
  output logic [2:0]                         hand,
  output logic [1:0]                         hand_n,
  output logic [$clog2(N_CARDS+1)-1:0]       stack_n,
  output logic [$clog2(N_CARDS+1)-1:0]       discard_n,
  output logic [2:0]                         lib_enacted,
  output logic [2:0]                         fas_enacted,
  output logic [2:0]                         peek,
  output logic                               done,
  output logic                               err
);

  localparam int CW = $clog2(N_CARDS + 1);
  localparam logic [N_CARDS-1:0] STACK_INIT = {{(N_CARDS-N_LIB){1'b0}}, {N_LIB{1'b1}}};

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_MERGE = 2'd1;
  localparam logic [1:0] S_SHUF  = 2'd2;

  localparam logic [1:0] P_NONE = 2'd0;
  localparam logic [1:0] P_DRAW = 2'd1;
  localparam logic [1:0] P_PEEK = 2'd2;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RESET   = 3'd1;
  localparam logic [2:0] OP_DRAW3   = 3'd2;
  localparam logic [2:0] OP_DISCARD = 3'd3;
  localparam logic [2:0] OP_ENACT   = 3'd4;
  localparam logic [2:0] OP_SHUFFLE = 3'd5;
  localparam logic [2:0] OP_PEEK3   = 3'd6;

  logic [1:0]         state_q, state_d;
  logic [1:0]         pend_q, pend_d;
  logic [N_CARDS-1:0] stack_q, stack_d;
  logic [N_CARDS-1:0] disc_q, disc_d;
  logic [CW-1:0]      stack_n_q, stack_n_d;
  logic [CW-1:0]      disc_n_q, disc_n_d;
  logic [CW-1:0]      i_q, i_d;
  logic [2:0]         hand_q, hand_d;
  logic [1:0]         hand_n_q, hand_n_d;
  logic [2:0]         lib_q, lib_d;
  logic [2:0]         fas_q, fas_d;
  logic [7:0]         lfsr_q, lfsr_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               w_fin;
  logic [CW-1:0]      w_j;
`ifdef POLICY_DECK_PEEK_EN
  logic [2:0]         peek_q, peek_d;
`endif

  assign w_j = lfsr_q[CW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= P_NONE;
      stack_q   <= STACK_INIT;
      disc_q    <= '0;
      stack_n_q <= CW'(N_CARDS);
      disc_n_q  <= '0;
      i_q       <= '0;
      hand_q    <= '0;
      hand_n_q  <= '0;
      lib_q     <= '0;
      fas_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef POLICY_DECK_PEEK_EN
      peek_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      stack_q   <= stack_d;
      disc_q    <= disc_d;
      stack_n_q <= stack_n_d;
      disc_n_q  <= disc_n_d;
      i_q       <= i_d;
      hand_q    <= hand_d;
      hand_n_q  <= hand_n_d;
      lib_q     <= lib_d;
      fas_q     <= fas_d;
      lfsr_q    <= lfsr_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef POLICY_DECK_PEEK_EN
      peek_q    <= peek_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    stack_d   = stack_q;
    disc_d    = disc_q;
    stack_n_d = stack_n_q;
    disc_n_d  = disc_n_q;
    i_d       = i_q;
    hand_d    = hand_q;
    hand_n_d  = hand_n_q;
    lib_d     = lib_q;
    fas_d     = fas_q;
    lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    done_d    = 1'b0;
    err_d     = 1'b0;
    w_fin     = 1'b0;
`ifdef POLICY_DECK_PEEK_EN
    peek_d    = peek_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          case (op_code)
            OP_NOP: done_d = 1'b1;
            OP_RESET: begin
              stack_d   = STACK_INIT;
              disc_d    = '0;
              stack_n_d = CW'(N_CARDS);
              disc_n_d  = '0;
              hand_d    = '0;
              hand_n_d  = '0;
              lib_d     = '0;
              fas_d     = '0;
              pend_d    = P_NONE;
              done_d    = 1'b1;
`ifdef POLICY_DECK_PEEK_EN
              peek_d    = '0;
`endif
            end
            OP_DRAW3: begin
              pend_d = P_DRAW;
              if (hand_n_q != 2'd0) begin
                err_d  = 1'b1;
                pend_d = pend_q;
              end else if (stack_n_q >= CW'(3)) w_fin = 1'b1;
              else state_d = S_MERGE;
            end
            OP_DISCARD: begin
              if (hand_n_q == 2'd3 && op_arg != 2'd3) begin
                disc_d   = disc_q | (N_CARDS'(hand_q[op_arg]) << disc_n_q);
                disc_n_d = disc_n_q + CW'(1);
                case (op_arg)
                  2'd0:    hand_d = {1'b0, hand_q[2], hand_q[1]};
                  2'd1:    hand_d = {1'b0, hand_q[2], hand_q[0]};
                  default: hand_d = {1'b0, hand_q[1], hand_q[0]};
                endcase
                hand_n_d = 2'd2;
                done_d   = 1'b1;
              end else err_d = 1'b1;
            end
            OP_ENACT: begin
              if (hand_n_q == 2'd2 && !op_arg[1] && lib_q < 3'd5 && fas_q < 3'd6) begin
                if (hand_q[op_arg[0]]) lib_d = lib_q + 3'd1;
                else                   fas_d = fas_q + 3'd1;
                disc_d   = disc_q | (N_CARDS'(hand_q[~op_arg[0]]) << disc_n_q);
                disc_n_d = disc_n_q + CW'(1);
                hand_d   = '0;
                hand_n_d = 2'd0;
                done_d   = 1'b1;
              end else err_d = 1'b1;
            end
            OP_SHUFFLE: begin
              pend_d  = P_NONE;
              state_d = S_MERGE;
            end
`ifdef POLICY_DECK_PEEK_EN
            OP_PEEK3: begin
              pend_d = P_PEEK;
              if (stack_n_q >= CW'(3)) w_fin = 1'b1;
              else state_d = S_MERGE;
            end
`endif
            default: err_d = 1'b1;
          endcase
        end
      end
      S_MERGE: begin
        stack_d   = stack_q | (disc_q << stack_n_q);
        stack_n_d = stack_n_q + disc_n_q;
        disc_d    = '0;
        disc_n_d  = '0;
        i_d       = stack_n_d - CW'(1);
        if (stack_n_d <= CW'(1)) w_fin = 1'b1;
        else state_d = S_SHUF;
      end
      S_SHUF: begin
        // Out-of-range draws simply retry with the next LFSR value.
        if (w_j <= i_q) begin
          stack_d[i_q] = stack_q[w_j];
          stack_d[w_j] = stack_q[i_q];
          i_d          = i_q - CW'(1);
          if (i_q == CW'(1)) w_fin = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Completion of a draw/peek, either immediate or after an auto-shuffle.
    if (w_fin) begin
      state_d = S_IDLE;
      case (pend_d)
        P_DRAW: begin
          if (stack_n_d >= CW'(3)) begin
            hand_d    = stack_d[2:0];
            stack_d   = stack_d >> 3;
            stack_n_d = stack_n_d - CW'(3);
            hand_n_d  = 2'd3;
            done_d    = 1'b1;
          end else err_d = 1'b1;
        end
        P_PEEK: begin
`ifdef POLICY_DECK_PEEK_EN
          peek_d = stack_d[2:0];
`endif
          done_d = 1'b1;
        end
        default: done_d = 1'b1;
      endcase
      pend_d = P_NONE;
    end
  end

  always_comb begin
    op_ready    = (state_q == S_IDLE);
    hand        = hand_q & ~(3'b111 << hand_n_q);
    hand_n      = hand_n_q;
    stack_n     = stack_n_q;
    discard_n   = disc_n_q;
    lib_enacted = lib_q;
    fas_enacted = fas_q;
    done        = done_q;
    err         = err_q;
`ifdef POLICY_DECK_PEEK_EN
    peek        = peek_q;
`else
    peek        = 3'b000;
`endif
  end

endmodule
`default_nettype wire
